// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI read arbiter.
//   - arb_state_t : arbiter FSM states
//   - ar_fields_t : AR fields latched at grant time
//   - axi_req_t / axi_resp_t : AXI master-to-slave and slave-to-master bundles.
//     The write-channel fields are carried so the bundles match the rest of the
//     SoC, but the read arbiter never uses them.
package axi_arb_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_ID_W   = 4;
  localparam int ARB_BEAT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
  } ar_fields_t;

  typedef struct packed {
    logic                    awvalid;
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    wvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    bready;
    logic                    arvalid;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    rready;
  } axi_req_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic                  bvalid;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  arready;
    logic                  rvalid;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
  } axi_resp_t;

endpackage

// File: rtl/axi_read_arbiter_rr.sv
// Combinational round-robin picker.
//   req       : one request bit per port
//   ptr       : highest-priority port for this pick
//   gnt_valid : at least one port is requesting
//   gnt_idx   : first requesting port at or after ptr, wrapping at N
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!gnt_valid && req[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read master among NUM_PORTS requesters, one whole burst at a
// time, in round-robin order, and checks each burst's beat count against arlen.
//   clk, rst_n  : clock, asynchronous active-low reset
//   s_axi_req   : per-requester AR/R request fields
//   s_axi_resp  : per-requester arready / R channel
//   m_axi_req   : to interconnect (write channel tied to zero, arid = 0)
//   m_axi_resp  : from interconnect
//   busy        : FSM not in IDLE
//   grant_id    : current or last granted port
//   proto_err   : sticky beat-count / arlen error
//   dbg_state   : FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid, once raised by the arbiter, is held with stable payload
// until that edge; ready may depend combinationally on valid.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MAX_ARLEN = 15,
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  axi_req_t         s_axi_req  [NUM_PORTS],
  output axi_resp_t        s_axi_resp [NUM_PORTS],
  output axi_req_t         m_axi_req,
  input  axi_resp_t        m_axi_resp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_id,
  output logic             proto_err,
  output arb_state_t       dbg_state
);

  localparam logic [7:0] MAX_ARLEN_L = 8'(MAX_ARLEN);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      grant_id_q, grant_id_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ARB_BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                  proto_err_q, proto_err_d;
  ar_fields_t            ar_q, ar_d;

  logic [NUM_PORTS-1:0]  req_vec;
  logic                  gnt_valid;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  beat;
  logic                  unused_ok;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) req_vec[p] = s_axi_req[p].arvalid;
  end

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req       (req_vec),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    proto_err_d = proto_err_q;
    ar_d        = ar_q;
    beat        = 1'b0;

    m_axi_req         = '0;
    m_axi_req.arvalid = (state_q == ADDR);
    m_axi_req.araddr  = ar_q.araddr;
    m_axi_req.arlen   = ar_q.arlen;
    m_axi_req.arsize  = ar_q.arsize;
    m_axi_req.arburst = ar_q.arburst;
    for (int p = 0; p < NUM_PORTS; p++) s_axi_resp[p] = '0;

    case (state_q)
      IDLE: begin
        // The requester gets no arready here; its request is copied and
        // replayed to the interconnect from ADDR.
        if (gnt_valid) begin
          grant_id_d   = gnt_idx;
          ar_d.araddr  = s_axi_req[gnt_idx].araddr;
          ar_d.arlen   = s_axi_req[gnt_idx].arlen;
          ar_d.arsize  = s_axi_req[gnt_idx].arsize;
          ar_d.arburst = s_axi_req[gnt_idx].arburst;
          if (s_axi_req[gnt_idx].arlen > MAX_ARLEN_L) proto_err_d = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // Issued even if the requester has since dropped arvalid.
        s_axi_resp[grant_id_q].arready = m_axi_resp.arready;
        if (m_axi_resp.arready) begin
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        m_axi_req.rready              = s_axi_req[grant_id_q].rready;
        s_axi_resp[grant_id_q].rvalid = m_axi_resp.rvalid;
        s_axi_resp[grant_id_q].rdata  = m_axi_resp.rdata;
        s_axi_resp[grant_id_q].rlast  = m_axi_resp.rlast;
        s_axi_resp[grant_id_q].rresp  = m_axi_resp.rresp;
        beat = m_axi_resp.rvalid && s_axi_req[grant_id_q].rready;
        if (beat) begin
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + ARB_BEAT_W'(1);
          // beat_cnt_q is the zero-based index of this beat, so the last beat
          // of a well-formed burst arrives with beat_cnt_q == arlen.
          if (m_axi_resp.rlast) begin
            if (beat_cnt_q != ar_q.arlen) proto_err_d = 1'b1;
            if (grant_id_q == IDX_W'(NUM_PORTS - 1)) rr_ptr_d = '0;
            else                                     rr_ptr_d = grant_id_q + IDX_W'(1);
            state_d = IDLE;
          end else if (beat_cnt_q >= ar_q.arlen) begin
            proto_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
      ar_q        <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
      ar_q        <= ar_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_id_q;
  assign proto_err = proto_err_q;
  assign dbg_state = state_q;

  // Write-channel and ID fields of the bundles are intentionally ignored.
  always_comb begin
    unused_ok = ^m_axi_resp;
    for (int p = 0; p < NUM_PORTS; p++) unused_ok = unused_ok ^ (^s_axi_req[p]);
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;
  import axi_arb_pkg::*;

  localparam int NUM_PORTS = 2;
  localparam int IDX_W     = 1;
  localparam int OBS_W     = 4 + AXI_DATA_W;

  logic             clk;
  logic             rst_n;
  axi_req_t         s_req  [NUM_PORTS];
  axi_resp_t        s_resp [NUM_PORTS];
  axi_req_t         m_req;
  axi_resp_t        m_resp;
  logic             busy;
  logic [IDX_W-1:0] grant_id;
  logic             proto_err;
  arb_state_t       dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [OBS_W-1:0] exp_q[$];
  logic [OBS_W-1:0] obs_q[$];

  axi_read_arbiter #(.NUM_PORTS(NUM_PORTS), .MAX_ARLEN(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axi_req  (s_req),
    .s_axi_resp (s_resp),
    .m_axi_req  (m_req),
    .m_axi_resp (m_resp),
    .busy       (busy),
    .grant_id   (grant_id),
    .proto_err  (proto_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic init_inputs();
    for (int p = 0; p < NUM_PORTS; p++) begin
      s_req[p]        = '0;
      s_req[p].rready = 1'b1;
    end
    m_resp = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    init_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic request(input int p, input logic [31:0] addr, input logic [7:0] len);
    s_req[p].arvalid = 1'b1;
    s_req[p].araddr  = addr;
    s_req[p].arlen   = len;
    s_req[p].arsize  = 3'd3;
    s_req[p].arburst = 2'd1;
  endtask

  // Wait (bounded) for the arbiter to present an AR; returns at negedge+1.
  task automatic wait_arvalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (m_req.arvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept();
    m_resp.arready = 1'b1;
    @(negedge clk);
    m_resp.arready = 1'b0;
  endtask

  // Drives n beats starting at the current negedge; records every beat a
  // requester accepts into obs_q as {port, rdata}.
  task automatic drive_beats(input int n, input int rlast_at, input logic [63:0] base);
    for (int b = 0; b < n; b++) begin
      m_resp.rvalid = 1'b1;
      m_resp.rdata  = base + 64'(b);
      m_resp.rlast  = (b + 1 == rlast_at);
      m_resp.rresp  = 2'd0;
      #1;
      for (int p = 0; p < NUM_PORTS; p++)
        if (s_resp[p].rvalid && s_req[p].rready) obs_q.push_back({4'(p), s_resp[p].rdata});
      @(negedge clk);
    end
    m_resp.rvalid = 1'b0;
    m_resp.rlast  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    init_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL reset_grant: got %b exp 0", grant_id); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", proto_err); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    checks++; if (m_req !== '0) begin failures++; $display("FAIL reset_m_req: got %h exp 0", m_req); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    obs_q.delete(); exp_q.delete();
    request(0, 32'h1FC0_0000, 8'd7);
    #1;
    checks++; if (m_req.arvalid !== 1'b0) begin failures++; $display("FAIL single_ar_latency: got %b exp 0", m_req.arvalid); end
    checks++; if (s_resp[0].arready !== 1'b0) begin failures++; $display("FAIL single_idle_arready: got %b exp 0", s_resp[0].arready); end
    wait_arvalid(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_ar_timeout: got %b exp 1", ok); end
    checks++; if (m_req.araddr !== 32'h1FC0_0000) begin failures++; $display("FAIL single_araddr: got %h exp 1fc00000", m_req.araddr); end
    checks++; if (m_req.arlen !== 8'd7) begin failures++; $display("FAIL single_arlen: got %0d exp 7", m_req.arlen); end
    checks++; if (m_req.arid !== '0) begin failures++; $display("FAIL single_arid: got %h exp 0", m_req.arid); end
    checks++; if (m_req.rready !== 1'b0) begin failures++; $display("FAIL single_rready_addr: got %b exp 0", m_req.rready); end
    m_resp.arready = 1'b1;
    #1;
    checks++; if (s_resp[0].arready !== 1'b1) begin failures++; $display("FAIL single_arready_p0: got %b exp 1", s_resp[0].arready); end
    checks++; if (s_resp[1].arready !== 1'b0) begin failures++; $display("FAIL single_arready_p1: got %b exp 0", s_resp[1].arready); end
    accept();
    s_req[0].arvalid = 1'b0;
    drive_beats(8, 8, 64'hA000_0000_0000_0000);
    for (int b = 0; b < 8; b++) exp_q.push_back({4'd0, 64'hA000_0000_0000_0000 + 64'(b)});
    #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL single_beat_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_beat%0d: got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: got busy=%b exp 0", busy); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL single_err: got %b exp 0", proto_err); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [31:0] addr [2];
    addr[0] = 32'h0000_1000;
    addr[1] = 32'h0000_2000;
    do_reset();
    obs_q.delete(); exp_q.delete();
    // Rounds 1-2: ports 0 and 1 together; round 3-4: together again.
    for (int r = 0; r < 4; r++) begin
      int p;
      p = r % 2;
      if (r == 0 || r == 2) begin
        request(0, addr[0], 8'd1);
        request(1, addr[1], 8'd1);
      end
      wait_arvalid(ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rr_ar_timeout%0d: got %b exp 1", r, ok); end
      checks++; if (grant_id !== IDX_W'(p)) begin failures++; $display("FAIL rr_grant%0d: got %0d exp %0d", r, grant_id, p); end
      checks++; if (m_req.araddr !== addr[p]) begin failures++; $display("FAIL rr_addr%0d: got %h exp %h", r, m_req.araddr, addr[p]); end
      accept();
      s_req[p].arvalid = 1'b0;
      drive_beats(2, 2, 64'(r) << 8);
      exp_q.push_back({4'(p), 64'(r) << 8});
      exp_q.push_back({4'(p), (64'(r) << 8) + 64'd1});
      #1;
      // Cycle right after rlast: still IDLE, no overlap with the pending request.
      checks++; if (m_req.arvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rr_no_overlap%0d: got arvalid=%b busy=%b exp 0 0", r, m_req.arvalid, busy); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rr_beat_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_beat%0d: got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_ar_stall();
    bit ok;
    obs_q.delete(); exp_q.delete();
    @(negedge clk);
    request(1, 32'h8000_0040, 8'd3);
    wait_arvalid(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_ar_timeout: got %b exp 1", ok); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) s_req[1].arvalid = 1'b0;
      checks++; if (m_req.arvalid !== 1'b1 || m_req.araddr !== 32'h8000_0040) begin failures++; $display("FAIL stall_hold%0d: got arvalid=%b addr=%h exp 1 80000040", i, m_req.arvalid, m_req.araddr); end
      checks++; if (s_resp[1].arready !== 1'b0) begin failures++; $display("FAIL stall_arready%0d: got %b exp 0", i, s_resp[1].arready); end
      @(negedge clk);
      #1;
    end
    m_resp.arready = 1'b1;
    #1;
    checks++; if (s_resp[1].arready !== 1'b1) begin failures++; $display("FAIL stall_arready_pass: got %b exp 1", s_resp[1].arready); end
    accept();
    drive_beats(4, 4, 64'hB0);
    for (int b = 0; b < 4; b++) exp_q.push_back({4'd1, 64'hB0 + 64'(b)});
    #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_beat_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_beat%0d: got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (busy !== 1'b0 || proto_err !== 1'b0) begin failures++; $display("FAIL stall_end: got busy=%b err=%b exp 0 0", busy, proto_err); end
  endtask

  task automatic test_beat_errors();
    bit ok;
    // Short burst: rlast on beat 2 of an arlen=3 burst.
    do_reset();
    request(0, 32'h100, 8'd3);
    wait_arvalid(ok);
    accept();
    s_req[0].arvalid = 1'b0;
    drive_beats(2, 2, 64'h0);
    #1;
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL short_err: got %b exp 1", proto_err); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL short_state: got %0d exp 0", dbg_state); end
    // A clean burst afterwards leaves the error set.
    request(0, 32'h200, 8'd3);
    wait_arvalid(ok);
    accept();
    s_req[0].arvalid = 1'b0;
    drive_beats(4, 4, 64'h0);
    #1;
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL sticky_err: got %b exp 1", proto_err); end
    // Exact burst after reset: no error.
    do_reset();
    #1;
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL err_reset_clear: got %b exp 0", proto_err); end
    request(0, 32'h300, 8'd3);
    wait_arvalid(ok);
    accept();
    s_req[0].arvalid = 1'b0;
    drive_beats(4, 4, 64'h0);
    #1;
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL exact_err: got %b exp 0", proto_err); end
    // Long burst: 4 beats without rlast, then the 5th carries rlast.
    request(0, 32'h400, 8'd3);
    wait_arvalid(ok);
    accept();
    s_req[0].arvalid = 1'b0;
    drive_beats(3, 0, 64'h0);
    #1;
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL long_err_early: got %b exp 0", proto_err); end
    drive_beats(1, 0, 64'h3);
    #1;
    checks++; if (proto_err !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL long_err_extra: got err=%b busy=%b exp 1 1", proto_err, busy); end
    drive_beats(1, 1, 64'h4);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL long_idle: got %b exp 0", busy); end
    // arlen above MAX_ARLEN: flagged at grant, burst still issued and drained.
    do_reset();
    request(0, 32'h500, 8'd16);
    wait_arvalid(ok);
    checks++; if (proto_err !== 1'b1 || m_req.arlen !== 8'd16) begin failures++; $display("FAIL maxlen: got err=%b arlen=%0d exp 1 16", proto_err, m_req.arlen); end
    accept();
    s_req[0].arvalid = 1'b0;
    drive_beats(17, 17, 64'h0);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL maxlen_idle: got %b exp 0", busy); end
  endtask

  task automatic test_rready_stall();
    bit ok;
    do_reset();
    obs_q.delete(); exp_q.delete();
    request(0, 32'h600, 8'd3);
    wait_arvalid(ok);
    accept();
    s_req[0].arvalid = 1'b0;
    s_req[0].rready  = 1'b0;
    m_resp.rvalid    = 1'b1;
    m_resp.rdata     = 64'hC0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m_req.rready !== 1'b0 || s_resp[0].rvalid !== 1'b1 || s_resp[0].rdata !== 64'hC0) begin
        failures++; $display("FAIL rstall%0d: got rready=%b rvalid=%b rdata=%h exp 0 1 c0", i, m_req.rready, s_resp[0].rvalid, s_resp[0].rdata);
      end
      @(negedge clk);
    end
    s_req[0].rready = 1'b1;
    drive_beats(4, 4, 64'hC0);
    for (int b = 0; b < 4; b++) exp_q.push_back({4'd0, 64'hC0 + 64'(b)});
    #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rstall_beat_count: got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstall_beat%0d: got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (proto_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstall_end: got err=%b busy=%b exp 0 0", proto_err, busy); end
  endtask

  task automatic test_reset_mid_data();
    bit ok;
    // rr pointer is 1 here (port 0 was served last); port 1 is the only requester.
    request(1, 32'h700, 8'd7);
    wait_arvalid(ok);
    checks++; if (grant_id !== 1'b1) begin failures++; $display("FAIL midrst_grant: got %b exp 1", grant_id); end
    accept();
    s_req[1].arvalid = 1'b0;
    drive_beats(3, 0, 64'hD0);
    m_resp.rvalid = 1'b1;
    m_resp.rdata  = 64'hD3;
    #1;
    checks++; if (s_resp[1].rvalid !== 1'b1) begin failures++; $display("FAIL midrst_pre: got %b exp 1", s_resp[1].rvalid); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || dbg_state !== IDLE || grant_id !== 1'b0) begin failures++; $display("FAIL midrst_regs: got busy=%b state=%0d grant=%b exp 0 0 0", busy, dbg_state, grant_id); end
    checks++; if (m_req !== '0) begin failures++; $display("FAIL midrst_m_req: got %h exp 0", m_req); end
    checks++; if (s_resp[0] !== '0 || s_resp[1] !== '0) begin failures++; $display("FAIL midrst_s_resp: got %h %h exp 0 0", s_resp[0], s_resp[1]); end
    init_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    request(0, 32'h800, 8'd0);
    request(1, 32'h900, 8'd0);
    wait_arvalid(ok);
    checks++; if (ok !== 1'b1 || grant_id !== 1'b0) begin failures++; $display("FAIL midrst_rr_ptr: got ok=%b grant=%b exp 1 0", ok, grant_id); end
    accept();
    s_req[0].arvalid = 1'b0;
    drive_beats(1, 1, 64'hE0);
    wait_arvalid(ok);
    checks++; if (ok !== 1'b1 || grant_id !== 1'b1) begin failures++; $display("FAIL midrst_second: got ok=%b grant=%b exp 1 1", ok, grant_id); end
    accept();
    s_req[1].arvalid = 1'b0;
    drive_beats(1, 1, 64'hE1);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ar_stall();
    test_beat_errors();
    test_rready_stall();
    test_reset_mid_data();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
